fifo_arbiter: RTL
=================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 8, maximum get count per read burst (range 1..16).
REQ-002 The block SHALL have parameter DW, default 8, data width.
REQ-003 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports req0, req1, input, 1 each, write requests from producers 0 and 1.
REQ-006 The block SHALL have ports wdata0, wdata1, input, DW each, producer write data.
REQ-007 The block SHALL have ports gnt0, gnt1, output, 1 each, write grants; a granted word is accepted that cycle.
REQ-008 The block SHALL have port flush, input, 1, single-cycle pulse requesting a full drain of the FIFO.
REQ-009 The block SHALL have ports fifo_full, fifo_empty, fifo_allmost_full, input, 1 each, FIFO status.
REQ-010 The block SHALL have port fifo_get_data, input, DW, FIFO head word.
REQ-011 The block SHALL have ports fifo_put, fifo_get, output, 1 each, and fifo_put_data, output, DW, FIFO controls.
REQ-012 The block SHALL have port out_ready, input, 1, consumer can take a word this cycle.
REQ-013 The block SHALL have ports out_valid, output, 1, and out_data, output, DW, consumer stream.
REQ-014 The block SHALL have port busy, output, 1, high while the read FSM is in BURST.

Function
REQ-015 Write arbitration SHALL be round-robin between req0 and req1 using a 1-bit priority pointer prio; at most one grant per cycle.
REQ-016 When fifo_full=1, gnt0=gnt1=fifo_put=0 regardless of requests.
REQ-017 When not full: one requester active -> it is granted; both active -> requester prio is granted.
REQ-018 After any grant, prio SHALL become the index of the non-granted requester; with no grant, prio holds.
REQ-019 fifo_put SHALL equal gnt0|gnt1, combinational, same cycle; fifo_put_data SHALL be wdata of the granted requester, else 0.
REQ-020 Read FSM SHALL have two states, IDLE and BURST.
REQ-021 IDLE -> BURST when fifo_allmost_full=1, or flush_pend=1 and fifo_empty=0; burst counter bcnt cleared to 0 on entry.
REQ-022 In BURST, fifo_get = out_ready & ~fifo_empty, combinational; in IDLE fifo_get=0.
REQ-023 out_valid SHALL equal fifo_get; out_data SHALL equal fifo_get_data when out_valid=1, else 0.
REQ-024 Each get SHALL increment bcnt (5-bit, no wrap within a burst).
REQ-025 BURST -> IDLE when a get occurs with bcnt=BURST_LEN-1, or fifo_empty=1 in BURST.
REQ-026 flush_pend SHALL be set by a flush pulse and cleared on a BURST -> IDLE transition caused by fifo_empty=1; a flush arriving in that same cycle SHALL keep it set.
REQ-027 While flush_pend=1, the FSM SHALL re-enter BURST back-to-back until the FIFO is empty.
REQ-028 Simultaneous fifo_put and fifo_get in one cycle SHALL be permitted.
REQ-029 busy SHALL be 1 exactly when state=BURST.

Reset
REQ-030 While rst=1, all outputs SHALL be 0, regardless of other inputs.
REQ-031 At the first clock edge with rst=1, state SHALL go to IDLE, and prio, bcnt and flush_pend SHALL go to 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no get SHALL be issued while rst=1.

Verification
REQ-033 Contention: req0=req1=1 for 4 cycles, FIFO not full, prio=0 -> grants 0,1,0,1, and fifo_put=1 in each of the 4 cycles.
REQ-034 Full block: fifo_full=1, req0=1 -> gnt0=0 and fifo_put=0; fifo_full drops -> gnt0=1 in that same cycle.
REQ-035 Threshold burst: fill to 15 words, out_ready=1 -> busy the next cycle, exactly 8 gets, then IDLE, 7 words remain.
REQ-036 Flush: 11 words, flush pulse -> bursts of 8 then 3, out_data in FIFO order, flush_pend=0 when empty.
REQ-037 Backpressure: out_ready=0 for 3 cycles mid-burst -> no gets and busy stays 1; burst resumes and still totals 8.
REQ-038 Reset mid-burst after 3 gets -> outputs 0 while rst=1, state IDLE; no further gets until a new start condition.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Round-robin write arbiter for two producers feeding an external FIFO, plus a
// burst read engine that drains the FIFO on a near-full threshold or a flush.
//
// state | meaning
// IDLE  | no reads; waiting for almost-full or a pending flush with data
// BURST | issuing gets whenever the consumer is ready, up to BURST_LEN words
module fifo_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  input  logic          flush,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic          fifo_allmost_full,
  input  logic [DW-1:0] fifo_get_data,
  output logic          fifo_put,
  output logic          fifo_get,
  output logic [DW-1:0] fifo_put_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [4:0] BCNT_LAST = 5'(BURST_LEN - 1);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [4:0] bcnt_q, bcnt_d;
  logic       flush_pend_q, flush_pend_d;
  logic       gnt0_c, gnt1_c, get_c;

  // Grants are combinational so a granted word lands in the FIFO the same cycle.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst && !fifo_full) begin
      if (req0 && (!req1 || !prio_q)) gnt0_c = 1'b1;
      else if (req1)                  gnt1_c = 1'b1;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0_c)      prio_d = 1'b1;
    else if (gnt1_c) prio_d = 1'b0;
  end

  assign get_c = !rst && (state_q == BURST) && out_ready && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    flush_pend_d = flush_pend_q | flush;
    case (state_q)
      IDLE: begin
        if (fifo_allmost_full || (flush_pend_q && !fifo_empty)) begin
          state_d = BURST;
          bcnt_d  = 5'd0;
        end
      end
      BURST: begin
        // Running dry ends the flush; a flush arriving now re-arms it.
        if (fifo_empty) begin
          state_d      = IDLE;
          flush_pend_d = flush;
        end else if (get_c) begin
          bcnt_d = bcnt_q + 5'd1;
          if (bcnt_q == BCNT_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      bcnt_q       <= 5'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      bcnt_q       <= bcnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign gnt0          = gnt0_c;
  assign gnt1          = gnt1_c;
  assign fifo_put      = gnt0_c | gnt1_c;
  assign fifo_put_data = gnt0_c ? wdata0 : (gnt1_c ? wdata1 : '0);
  assign fifo_get      = get_c;
  assign out_valid     = get_c;
  assign out_data      = get_c ? fifo_get_data : '0;
  assign busy          = !rst && (state_q == BURST);

endmodule
